// File: rtl/seq_muldiv_unit.sv
// Iterative signed multiply/divide unit: one multiplier or quotient bit per cycle,
// start/done handshake, remainder output and ALU-compatible flag word.
module seq_muldiv_unit #(
  parameter int l = 16,
  parameter int p = 1
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Start,
  input  logic [p:0]   Operation,
  input  logic [l-1:0] B,
  input  logic [l-1:0] C,
  input  logic [l-1:0] FlagsIn,
  output logic         Ready,
  output logic         Done,
  output logic [l-1:0] Res,
  output logic [l-1:0] Rem,
  output logic [l-1:0] FlagsOut,
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(l);
  localparam logic [l-1:0] HALF = {1'b1, {(l-1){1'b0}}};
  localparam logic [p:0] OP_DIV = '0;
  localparam logic [p:0] OP_MUL = {{p{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  typedef enum logic [1:0] {K_DIV, K_MUL, K_DIVZ, K_NOP} kind_t;

  state_t          state;
  kind_t           kind;
  logic            sign;
  logic            b_neg;
  logic [l-1:0]    flags_cap;
  logic [2*l-1:0]  mcand;
  logic [l-1:0]    mplier;
  logic [2*l-1:0]  prod;
  logic [l-1:0]    divisor;
  logic [l-1:0]    quo;
  logic [l-1:0]    rmd;
  logic [CW-1:0]   cnt;

  logic [l-1:0]    abs_b;
  logic [l-1:0]    abs_c;
  logic [l:0]      trial;
  logic [l-1:0]    diff;
  logic [l-1:0]    prod_lo;
  logic [l-1:0]    fin_res;
  logic [l-1:0]    fin_rem;
  logic [l-1:0]    fin_flags;

  // Magnitude fits the signed range only up to 2^(l-1) when the result is negative.
  function automatic logic out_range(input logic [l-1:0] v, input logic s);
    return s ? (v > HALF) : (v >= HALF);
  endfunction

  assign abs_b     = B[l-1] ? -B : B;
  assign abs_c     = C[l-1] ? -C : C;
  assign trial     = {rmd, quo[l-1]};
  assign diff      = trial[l-1:0] - divisor;
  assign prod_lo   = prod[l-1:0];
  assign dbg_state = state;

  always_comb begin
    fin_res   = '0;
    fin_rem   = '0;
    fin_flags = flags_cap;
    case (kind)
      K_MUL: begin
        fin_res      = sign ? -prod_lo : prod_lo;
        fin_flags[0] = (|prod[2*l-1:l]) | out_range(prod_lo, sign);
      end
      K_DIV: begin
        fin_res      = sign ? -quo : quo;
        fin_rem      = b_neg ? -rmd : rmd;
        fin_flags[1] = |rmd;
        fin_flags[2] = 1'b0;
        fin_flags[3] = out_range(quo, sign);
      end
      K_DIVZ: begin
        // quo still holds |B| because RUN was skipped
        fin_rem      = b_neg ? -quo : quo;
        fin_flags[1] = 1'b0;
        fin_flags[2] = 1'b1;
        fin_flags[3] = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      kind      <= K_NOP;
      Ready     <= 1'b1;
      Done      <= 1'b0;
      Res       <= '0;
      Rem       <= '0;
      FlagsOut  <= '0;
      sign      <= 1'b0;
      b_neg     <= 1'b0;
      flags_cap <= '0;
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      divisor   <= '0;
      quo       <= '0;
      rmd       <= '0;
      cnt       <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            Ready     <= 1'b0;
            sign      <= B[l-1] ^ C[l-1];
            b_neg     <= B[l-1];
            flags_cap <= FlagsIn;
            mcand     <= {{l{1'b0}}, abs_b};
            mplier    <= abs_c;
            prod      <= '0;
            divisor   <= abs_c;
            quo       <= abs_b;
            rmd       <= '0;
            cnt       <= CW'(l - 1);
            if (Operation == OP_MUL) begin
              kind  <= K_MUL;
              state <= RUN;
            end else if (Operation == OP_DIV) begin
              if (C == '0) begin
                kind  <= K_DIVZ;
                state <= FINISH;
              end else begin
                kind  <= K_DIV;
                state <= RUN;
              end
            end else begin
              kind  <= K_NOP;
              state <= FINISH;
            end
          end
        end
        RUN: begin
          if (kind == K_MUL) begin
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end else begin
            // Restoring step: l+1-bit compare, subtract only when it fits
            if (trial >= {1'b0, divisor}) begin
              rmd <= diff;
              quo <= {quo[l-2:0], 1'b1};
            end else begin
              rmd <= trial[l-1:0];
              quo <= {quo[l-2:0], 1'b0};
            end
          end
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= FINISH;
        end
        FINISH: begin
          Res      <= fin_res;
          Rem      <= fin_rem;
          FlagsOut <= fin_flags;
          Done     <= 1'b1;
          Ready    <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Directed bench for seq_muldiv_unit (l=16): multiply, divide, divide-by-zero,
// no-op, ignored Start, back-to-back issue and reset abort.
module tb_seq_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] b;
  logic [15:0] c;
  logic [15:0] flags_in;
  logic        ready;
  logic        done;
  logic [15:0] res;
  logic [15:0] rem;
  logic [15:0] flags_out;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [47:0] exp_q[$];

  seq_muldiv_unit #(.l(16), .p(1)) dut (
    .Clock(clk), .Reset(rst), .Start(start), .Operation(op),
    .B(b), .C(c), .FlagsIn(flags_in),
    .Ready(ready), .Done(done), .Res(res), .Rem(rem), .FlagsOut(flags_out),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one operation, scramble inputs after accept, and return the number of
  // edges from accept until Done is seen (-1 if it never comes).
  task automatic issue(input logic [1:0] o, input logic [15:0] bv, input logic [15:0] cv,
                       input logic [15:0] fv, output int lat);
    int k;
    start = 1'b1; op = o; b = bv; c = cv; flags_in = fv;
    @(posedge clk); #1;
    start = 1'b0; op = 2'd3; b = ~bv; c = 16'h5A5A; flags_in = ~fv;
    lat = -1;
    k = 0;
    while (lat < 0 && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (done) lat = k;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'd0; b = '0; c = '0; flags_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if ({res, rem, flags_out} !== 48'h0) begin errors++;
      $display("FAIL reset_outputs got %h %h %h exp 0 0 0", res, rem, flags_out); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
  endtask

  task automatic test_mul();
    logic [15:0] vb[5] = '{16'h0007, 16'h012C, 16'h8000, 16'h8000, 16'h0003};
    logic [15:0] vc[5] = '{16'hFFFD, 16'h00C8, 16'h0001, 16'hFFFF, 16'h0005};
    logic [15:0] vf[5] = '{16'h000E, 16'h0000, 16'h0000, 16'h0000, 16'hF001};
    logic [15:0] er[5] = '{16'hFFEB, 16'hEA60, 16'h8000, 16'h8000, 16'h000F};
    logic [15:0] ef[5] = '{16'h000E, 16'h0001, 16'h0000, 16'h0001, 16'hF000};
    int lat;
    for (int i = 0; i < 5; i++) begin
      issue(2'd1, vb[i], vc[i], vf[i], lat);
      checks++; if (lat !== 17) begin errors++; $display("FAIL mul%0d_latency got %0d exp 17", i, lat); end
      checks++; if (res !== er[i]) begin errors++; $display("FAIL mul%0d_res got %h exp %h", i, res, er[i]); end
      checks++; if (rem !== 16'h0) begin errors++; $display("FAIL mul%0d_rem got %h exp 0000", i, rem); end
      checks++; if (flags_out !== ef[i]) begin errors++;
        $display("FAIL mul%0d_flags got %h exp %h", i, flags_out, ef[i]); end
    end
  endtask

  task automatic test_div();
    logic [15:0] vb[3] = '{16'hFFF9, 16'h8000, 16'h0064};
    logic [15:0] vc[3] = '{16'h0002, 16'hFFFF, 16'hFFF9};
    logic [15:0] vf[3] = '{16'h0001, 16'h0001, 16'h000C};
    logic [15:0] er[3] = '{16'hFFFD, 16'h8000, 16'hFFF2};
    logic [15:0] em[3] = '{16'hFFFF, 16'h0000, 16'h0002};
    logic [15:0] ef[3] = '{16'h0003, 16'h0009, 16'h0002};
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue(2'd0, vb[i], vc[i], vf[i], lat);
      checks++; if (lat !== 17) begin errors++; $display("FAIL div%0d_latency got %0d exp 17", i, lat); end
      checks++; if (res !== er[i]) begin errors++; $display("FAIL div%0d_res got %h exp %h", i, res, er[i]); end
      checks++; if (rem !== em[i]) begin errors++; $display("FAIL div%0d_rem got %h exp %h", i, rem, em[i]); end
      checks++; if (flags_out !== ef[i]) begin errors++;
        $display("FAIL div%0d_flags got %h exp %h", i, flags_out, ef[i]); end
    end
  endtask

  task automatic test_div_zero_and_noop();
    logic [1:0]  vo[3] = '{2'd0, 2'd0, 2'd2};
    logic [15:0] vb[3] = '{16'h0007, 16'hFFF9, 16'h1234};
    logic [15:0] vc[3] = '{16'h0000, 16'h0000, 16'h5678};
    logic [15:0] vf[3] = '{16'hF000, 16'hF001, 16'hA5A5};
    logic [15:0] em[3] = '{16'h0007, 16'hFFF9, 16'h0000};
    logic [15:0] ef[3] = '{16'hF004, 16'hF005, 16'hA5A5};
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue(vo[i], vb[i], vc[i], vf[i], lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL short%0d_latency got %0d exp 1", i, lat); end
      checks++; if (res !== 16'h0) begin errors++; $display("FAIL short%0d_res got %h exp 0000", i, res); end
      checks++; if (rem !== em[i]) begin errors++; $display("FAIL short%0d_rem got %h exp %h", i, rem, em[i]); end
      checks++; if (flags_out !== ef[i]) begin errors++;
        $display("FAIL short%0d_flags got %h exp %h", i, flags_out, ef[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int k;
    logic [47:0] e;
    exp_q.push_back({16'hFFEB, 16'h0000, 16'h0000});
    exp_q.push_back({16'hFFFD, 16'hFFFF, 16'h0002});
    start = 1'b1; op = 2'd1; b = 16'h0007; c = 16'hFFFD; flags_in = 16'h0000;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; k = 0;
    while (lat < 0 && k < 40) begin
      @(posedge clk); #1;
      k++;
      start = 1'b0;
      if (done) lat = k;
      else if (k == 3) begin
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_busy_ready got %b exp 0", ready); end
        start = 1'b1; op = 2'd2; b = 16'h1111; c = 16'h2222;
      end
    end
    e = exp_q.pop_front();
    checks++; if (lat !== 17) begin errors++; $display("FAIL b2b_first_latency got %0d exp 17", lat); end
    checks++; if ({res, rem, flags_out} !== e) begin errors++;
      $display("FAIL b2b_first_result got %h %h %h exp %h", res, rem, flags_out, e); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_done_ready got %b exp 1", ready); end
    // new issue in the Done cycle
    start = 1'b1; op = 2'd0; b = 16'hFFF9; c = 16'h0002; flags_in = 16'h0000;
    @(posedge clk); #1;
    start = 1'b0; b = 16'h0000; c = 16'h0000;
    checks++; if ({ready, done} !== 2'b00) begin errors++;
      $display("FAIL b2b_accept got ready=%b done=%b exp 0 0", ready, done); end
    lat = -1; k = 0;
    while (lat < 0 && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (done) lat = k;
      else if (k == 5) begin
        checks++; if (res !== 16'hFFEB) begin errors++; $display("FAIL b2b_hold_res got %h exp ffeb", res); end
      end
    end
    e = exp_q.pop_front();
    checks++; if (lat !== 17) begin errors++; $display("FAIL b2b_second_latency got %0d exp 17", lat); end
    checks++; if ({res, rem, flags_out} !== e) begin errors++;
      $display("FAIL b2b_second_result got %h %h %h exp %h", res, rem, flags_out, e); end
  endtask

  task automatic test_reset_abort();
    int pulses;
    start = 1'b1; op = 2'd1; b = 16'h012C; c = 16'h00C8; flags_in = 16'hF00F;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({ready, done} !== 2'b10) begin errors++;
      $display("FAIL abort_handshake got ready=%b done=%b exp 1 0", ready, done); end
    checks++; if ({res, rem, flags_out} !== 48'h0) begin errors++;
      $display("FAIL abort_outputs got %h %h %h exp 0 0 0", res, rem, flags_out); end
    pulses = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses exp 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero_and_noop();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
